// File: rtl/load_ext_ctrl.sv
// Load controller: issues one word read per load request, then aligns
// and sign/zero-extends the selected byte/halfword/word for writeback.
// Misaligned requests raise exc_adel; a memory that never acks raises exc_bus.
module load_ext_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_type,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        exc_adel,
    output logic        exc_bus,
    output logic        busy
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         addr_lo;
    logic [2:0]         type_q;

    // Only the lane-select bits of the address matter after the request is issued.
    assign ld_ready = (state == IDLE) & ~rst;

    // Halfword loads are LH/LHU; byte loads are LB/LBU; everything else is a word.
    function automatic logic is_byte(input logic [2:0] t);
        return (t == 3'b000) || (t == 3'b100);
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b101);
    endfunction

    function automatic logic misaligned(input logic [1:0] a, input logic [2:0] t);
        if (is_byte(t))
            return 1'b0;
        else if (is_half(t))
            return a[0];
        else
            return a != 2'b00;
    endfunction

    // Lane select plus sign/zero extension of the returned word.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_lo  <= '0;
            type_q   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            exc_adel <= 1'b0;
            exc_bus  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            exc_adel <= 1'b0;
            exc_bus  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        addr_lo <= ld_addr[1:0];
                        type_q  <= ld_type;
                        busy    <= 1'b1;
                        if (misaligned(ld_addr[1:0], ld_type)) begin
                            state    <= ERR;
                            exc_adel <= 1'b1;
                        end else begin
                            state    <= REQ;
                            cnt      <= '0;
                            mem_req  <= 1'b1;
                            mem_addr <= {ld_addr[31:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        rd_valid <= 1'b1;
                        rd_data  <= extend(mem_rdata, addr_lo, type_q);
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= ERR;
                        exc_bus  <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Scoreboard bench for load_ext_ctrl: stimulus pushes expected result
// events (kind, data, cycle); a negedge monitor pops and compares them.
module tb_load_ext_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_type;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        exc_adel;
    logic        exc_bus;
    logic        busy;

    load_ext_ctrl #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_type   (ld_type),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .exc_adel  (exc_adel),
        .exc_bus   (exc_bus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Kinds are {rd_valid, exc_adel, exc_bus}.
    localparam logic [2:0] K_RD   = 3'b100;
    localparam logic [2:0] K_ADEL = 3'b010;
    localparam logic [2:0] K_BUS  = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc;
    logic [31:0] last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any result/exception pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid || exc_adel || exc_bus) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({rd_valid, exc_adel, exc_bus}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ev_kind", 32'({rd_valid, exc_adel, exc_bus}), 32'(e.kind));
                check("ev_cycle", 32'(cyc), e.cyc);
                check("ev_data", rd_data, e.data);
            end
        end
    end

    // Present a request (called #1 after an edge); returns #1 after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [2:0] t, input bit hold);
        int n;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_type  = t;
        n = 0;
        while (!ld_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ld_ready) check("ready_timeout", 32'(ld_ready), 32'd1);
        acc = cyc + 1;
        @(posedge clk); #1;
        if (!hold) ld_valid = 1'b0;
    endtask

    // Aligned load with w wait cycles before mem_ack.
    task automatic run_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] rdata,
                            input int w, input logic [31:0] exp);
        issue(a, t, 1'b0);
        sb.push_back('{K_RD, exp, 32'(acc + w + 1)});
        mem_rdata = rdata;
        for (int i = 0; i <= w; i++) begin
            mem_ack = (i == w);
            @(negedge clk);
            check("req_high", 32'(mem_req), 32'd1);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_ready", 32'(ld_ready), 32'd1);
        check("idle_addr", mem_addr, 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        last = exp;
    endtask

    // Misaligned load: no memory request, one exc_adel, rd_data unchanged.
    task automatic run_adel(input logic [31:0] a, input logic [2:0] t);
        issue(a, t, 1'b0);
        sb.push_back('{K_ADEL, last, 32'(acc)});
        @(negedge clk);
        check("adel_no_req", 32'(mem_req), 32'd0);
        check("adel_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("adel_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_type   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        last      = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready_low", 32'(ld_ready), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ld_ready), 32'd1);
        check("post_rst_addr", mem_addr, 32'd0);
        @(posedge clk); #1;

        run_load(32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 32'hFFFF_FF80);
        run_load(32'h0000_2002, 3'b101, 32'hBEEF_0001, 3, 32'h0000_BEEF);

        run_adel(32'h0000_3001, 3'b011);
        run_adel(32'h0000_3001, 3'b001);
        run_adel(32'h0000_3002, 3'b111);
        run_adel(32'h0000_3003, 3'b101);

        // Timeout: 15 request cycles, then one exc_bus.
        issue(32'h0000_4000, 3'b011, 1'b0);
        sb.push_back('{K_BUS, last, 32'(acc + 15)});
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("to_req_high", 32'(mem_req), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_req_low", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;

        run_load(32'h0000_6002, 3'b001, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        run_load(32'h0000_6000, 3'b001, 32'h8001_7FFF, 0, 32'h0000_7FFF);
        run_load(32'h0000_7000, 3'b010, 32'h1234_5678, 2, 32'h1234_5678);
        run_load(32'h0000_7001, 3'b000, 32'h0000_8000, 0, 32'hFFFF_FF80);
        run_load(32'h0000_1000, 3'b101, 32'h0000_8001, 5, 32'h0000_8001);
        run_load(32'h0000_8004, 3'b011, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        run_load(32'h0000_8003, 3'b100, 32'hA500_0000, 1, 32'h0000_00A5);

        // Reset in the second request cycle; the late ack must be ignored.
        issue(32'h0000_5000, 3'b001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_in_rst", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_ready", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        last    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back with ld_valid held: LB 0x0 then LBU 0x1.
        mem_rdata = 32'h0000_F07F;
        issue(32'h0000_0000, 3'b000, 1'b1);
        ld_addr = 32'h0000_0001;
        ld_type = 3'b100;
        sb.push_back('{K_RD, 32'h0000_007F, 32'(acc + 1)});
        sb.push_back('{K_RD, 32'h0000_00F0, 32'(acc + 4)});
        mem_ack = 1'b1;
        @(negedge clk);
        check("b2b_ready_req", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("b2b_ready_resp", 32'(ld_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_ready_gap", 32'(ld_ready), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        mem_ack  = 1'b1;
        @(negedge clk);
        check("b2b_second_req", 32'(mem_req), 32'd1);
        check("b2b_second_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_ext_ctrl.md
LOAD_EXT_CTRL -- requirements
Module: load_ext_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max mem_req cycles without mem_ack before bus error (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ld_valid  input  1  load request from MEM stage.
REQ-005 SHALL have port ld_ready  output  1  controller can accept a request.
REQ-006 SHALL have port ld_addr  input  32  byte address of load.
REQ-007 SHALL have port ld_type  input  3  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; 010/110/111 treated as LW.
REQ-008 SHALL have port mem_req  output  1  data-memory read request.
REQ-009 SHALL have port mem_addr  output  32  word-aligned read address.
REQ-010 SHALL have port mem_ack  input  1  memory returns mem_rdata this cycle.
REQ-011 SHALL have port mem_rdata  input  32  read word, little-endian lanes.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port rd_data  output  32  aligned, extended load result.
REQ-014 SHALL have port exc_adel  output  1  one-cycle pulse, address-error-on-load.
REQ-015 SHALL have port exc_bus  output  1  one-cycle pulse, memory timeout.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE (pipeline stall).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RESP, ERR.
REQ-018 SHALL drive ld_ready = (state==IDLE) & ~rst, combinationally.
REQ-019 SHALL accept on ld_valid & ld_ready; latch ld_addr and ld_type; inputs ignored otherwise.
REQ-020 SHALL flag misalignment at accept: LH/LHU with addr[0]=1, or LW (incl. reserved types) with addr[1:0]!=0; then IDLE->ERR, no mem_req issued.
REQ-021 SHALL otherwise go IDLE->REQ; in REQ hold mem_req=1 and mem_addr={addr[31:2],2'b00} stable until exit.
REQ-022 SHALL in REQ on mem_ack=1 capture mem_rdata that cycle and go to RESP; mem_ack outside REQ ignored.
REQ-023 SHALL count REQ cycles without mem_ack in an 8-bit counter cleared on entry to REQ; on count reaching TIMEOUT (mem_ack low), go to ERR with bus cause, mem_req low next cycle.
REQ-024 SHALL in RESP assert rd_valid for exactly one cycle, then return to IDLE.
REQ-025 SHALL select byte = rdata[8*addr[1:0]+7 : 8*addr[1:0]] and halfword = rdata[16*addr[1]+15 : 16*addr[1]].
REQ-026 SHALL sign-extend for LB/LH (replicate bit 7/15 to bit 31), zero-extend for LBU/LHU, pass word for LW.
REQ-027 SHALL register rd_data in RESP and hold it until the next rd_valid; unchanged on errors.
REQ-028 SHALL in ERR assert exactly one of exc_adel or exc_bus for one cycle, then return to IDLE.
REQ-029 SHALL give latency: accept at edge N, mem_req high cycle N+1; ack in cycle N+k (k>=1) -> rd_valid in cycle N+k+1.
REQ-030 SHALL accept a new request in the cycle after RESP/ERR (back-to-back gap of one IDLE cycle).

Reset
REQ-031 SHALL on rst=1 at a clock edge enter IDLE, clear counter, latched request and rd_data to 0, force mem_req, rd_valid, exc_adel, exc_bus, busy to 0 next cycle.
REQ-032 SHALL abort any in-flight request on rst mid-operation without producing rd_valid or exceptions; a late mem_ack after reset is ignored.
REQ-033 SHALL keep mem_addr at 0 when state is IDLE.

Verification
REQ-034 LB addr 0x1003, ack in first REQ cycle, rdata 0x80FF_1234 -> rd_valid 2 cycles after accept, rd_data 0xFFFF_FF80.
REQ-035 LHU addr 0x2002, ack after 3 wait cycles, rdata 0xBEEF_0001 -> mem_addr 0x2000 held 4 cycles, rd_data 0x0000_BEEF.
REQ-036 LW addr 0x3001 -> no mem_req, exc_adel pulse cycle after accept, rd_data unchanged; LH addr 0x3001 -> same.
REQ-037 LW addr 0x4000, TIMEOUT=15, mem_ack never -> mem_req high 15 cycles, then exc_bus one pulse, ld_ready high next cycle.
REQ-038 LH addr 0x5000 accepted, rst asserted in 2nd REQ cycle, mem_ack next cycle -> no rd_valid, outputs 0, ld_ready high after rst drops.
REQ-039 Back-to-back LB 0x0 and LBU 0x1 with ld_valid held, rdata 0x0000_F07F both -> results 0x0000_007F then 0x0000_00F0, one IDLE gap.
